// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter, receiver and baud
// generator.
//   uart_state_e - frame FSM state. TX and RX both use it.
//   OVERSAMPLE   - receive oversample ticks per bit.
//   DATA_BITS    - data bits per frame.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_if.sv
// uart_if: byte-level bus between the register front end and the UART.
//   wr_en   - one-cycle write strobe. din is taken when busy is 0.
//   din     - byte to transmit.
//   rdy_clr - clears the sticky rdy flag.
//   busy    - a transmit frame is in progress.
//   rdy     - received byte valid. Stays set until rdy_clr.
//   dout    - last received byte.
// The master modport is the front end. The slave modport is the UART.
interface uart_if;
    logic       wr_en;
    logic [7:0] din;
    logic       rdy_clr;
    logic       busy;
    logic       rdy;
    logic [7:0] dout;

    modport master (output wr_en, output din, output rdy_clr,
                    input  busy,  input  rdy, input  dout);
    modport slave  (input  wr_en, input  din, input  rdy_clr,
                    output busy,  output rdy, output dout);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divide-by-DIV counter that gives a one-cycle tick.
//   clk     - system clock.
//   rst     - asynchronous active-low reset.
//   restart - synchronous restart. It zeroes the count, so the first tick
//             comes DIV clocks later.
//   tick    - high for one cycle every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == W'(DIV - 1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tick = (cnt_reg == W'(DIV - 1));
endmodule

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART.
//   clk - system clock, rising edge.
//   rst - asynchronous active-low reset.
//   rx  - serial input, idle high.
//   tx  - serial output, idle high.
//   bus - uart_if.slave: wr_en/din/rdy_clr in, busy/rdy/dout out.
// The TX frame is timed by a bit-rate divider that restarts on accept.
// The RX side uses a free-running 16x oversample divider.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    uart_if.slave bus
);
    localparam int TX_DIV = CLK_FREQ / BAUD;
    localparam int RX_DIV = CLK_FREQ / (OVERSAMPLE * BAUD);

    // ---------------- transmitter ----------------
    uart_state_e tx_state_reg, tx_state_next;
    logic        tx_reg, tx_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic        tx_accept, tx_tick;

    uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
        .clk(clk), .rst(rst), .restart(tx_accept), .tick(tx_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= IDLE;
            tx_reg       <= 1'b1;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_reg       <= tx_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
        end
    end

    // tx is registered. On the accept edge it drops to the start bit
    // together with the state change.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_next       = tx_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_accept     = 1'b0;
        case (tx_state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (bus.wr_en) begin
                    tx_accept     = 1'b1;
                    tx_shift_next = bus.din;
                    tx_bit_next   = '0;
                    tx_next       = 1'b0;
                    tx_state_next = START;
                end
            end
            START: if (tx_tick) begin
                tx_next       = tx_shift_reg[0];
                tx_state_next = DATA;
            end
            DATA: if (tx_tick) begin
                if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
                    tx_next       = 1'b1;
                    tx_state_next = STOP;
                end else begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_next       = tx_shift_reg[1];
                    tx_bit_next   = tx_bit_reg + 3'd1;
                end
            end
            STOP: if (tx_tick) begin
                tx_next       = 1'b1;
                tx_state_next = IDLE;
            end
            default: tx_state_next = IDLE;
        endcase
    end

    assign tx       = tx_reg;
    assign bus.busy = (tx_state_reg != IDLE);

    // ---------------- receiver ----------------
    uart_state_e rx_state_reg, rx_state_next;
    logic [1:0]  rx_sync_reg;
    logic [3:0]  rx_sample_reg, rx_sample_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [7:0]  dout_reg, dout_next;
    logic        rdy_reg, rdy_next;
    logic        rx_tick, rx_in;

    uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
        .clk(clk), .rst(rst), .restart(1'b0), .tick(rx_tick)
    );

    // Two-flop synchroniser. Both flops reset to the idle level so that
    // reset is not read as a start bit.
    assign rx_in = rx_sync_reg[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_reg   <= 2'b11;
            rx_state_reg  <= IDLE;
            rx_sample_reg <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            dout_reg      <= '0;
            rdy_reg       <= 1'b0;
        end else begin
            rx_sync_reg   <= {rx_sync_reg[0], rx};
            rx_state_reg  <= rx_state_next;
            rx_sample_reg <= rx_sample_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            dout_reg      <= dout_next;
            rdy_reg       <= rdy_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_sample_next = rx_sample_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        dout_next      = dout_reg;
        // Clear first, so a byte completing in the same cycle sets rdy.
        rdy_next       = bus.rdy_clr ? 1'b0 : rdy_reg;
        if (rx_tick) begin
            case (rx_state_reg)
                IDLE: if (!rx_in) begin
                    rx_sample_next = '0;
                    rx_state_next  = START;
                end
                START: begin
                    if (rx_sample_reg == 4'(OVERSAMPLE / 2 - 1)) begin
                        // Mid start bit. A high line here was a glitch.
                        rx_sample_next = '0;
                        rx_bit_next    = '0;
                        rx_state_next  = rx_in ? IDLE : DATA;
                    end else begin
                        rx_sample_next = rx_sample_reg + 4'd1;
                    end
                end
                DATA: begin
                    rx_sample_next = rx_sample_reg + 4'd1;
                    if (rx_sample_reg == 4'(OVERSAMPLE - 1)) begin
                        rx_shift_next = {rx_in, rx_shift_reg[7:1]};
                        rx_bit_next   = rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'(DATA_BITS - 1)) begin
                            rx_state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    rx_sample_next = rx_sample_reg + 4'd1;
                    if (rx_sample_reg == 4'(OVERSAMPLE - 1)) begin
                        // A low stop bit is a framing error, so drop the byte.
                        if (rx_in) begin
                            dout_next = rx_shift_reg;
                            rdy_next  = 1'b1;
                        end
                        rx_state_next = IDLE;
                    end
                end
                default: rx_state_next = IDLE;
            endcase
        end
    end

    assign bus.rdy  = rdy_reg;
    assign bus.dout = dout_reg;
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed bench for uart_top at the default 434 / 27 dividers.
// Loopback vectors are table driven. The false start, framing error and
// mid-frame reset cases are hand-written sequences.
module tb_uart_top;
    localparam int BIT_CLKS   = 434;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    localparam int TICK_CLKS  = 27;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic loop_en = 1'b1;
    logic rx_drv = 1'b1;
    logic rx, tx;

    uart_if bus_if();

    assign rx = loop_en ? tx : rx_drv;

    uart_top dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       inject;   // write 0xAA mid-frame, which must be ignored
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    // Writes one byte over loopback and walks the whole frame.
    task automatic tx_frame(input logic [7:0] data, input logic inject, input logic [7:0] exp_dout);
        logic [9:0] frame;
        int k;
        int rdy_k;
        frame = {1'b1, data, 1'b0};
        @(negedge clk);
        bus_if.din   = data;
        bus_if.wr_en = 1'b1;
        @(posedge clk); #1;
        bus_if.wr_en = 1'b0;
        check("accept_tx_low", 32'(tx), 32'd0);
        check("accept_busy", 32'(bus_if.busy), 32'd1);
        k = 0;
        rdy_k = -1;
        while (bus_if.busy && k < FRAME_CLKS + 100) begin
            @(posedge clk); #1;
            k++;
            if (inject && k == 2000) begin
                bus_if.din   = 8'hAA;
                bus_if.wr_en = 1'b1;
            end
            if (inject && k == 2001) bus_if.wr_en = 1'b0;
            if (k % BIT_CLKS == BIT_CLKS / 2 && k < FRAME_CLKS)
                check($sformatf("tx_bit%0d", k / BIT_CLKS), 32'(tx), 32'(frame[k / BIT_CLKS]));
            if (bus_if.rdy && rdy_k < 0) rdy_k = k;
        end
        check("busy_len", 32'(k), 32'(FRAME_CLKS));
        check("rdy_before_busy_fall", 32'(rdy_k > 0 && rdy_k < FRAME_CLKS), 32'd1);
        check("rdy_set", 32'(bus_if.rdy), 32'd1);
        check("dout", 32'(bus_if.dout), 32'(exp_dout));
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_frame", 32'(bus_if.busy), 32'd0);
        check("rdy_held", 32'(bus_if.rdy), 32'd1);
        @(negedge clk);
        bus_if.rdy_clr = 1'b1;
        @(posedge clk); #1;
        bus_if.rdy_clr = 1'b0;
        check("rdy_clr", 32'(bus_if.rdy), 32'd0);
    endtask

    // Drives one frame on rx directly. A bad stop bit is held low for only
    // part of a bit time, so the receiver sees a false start afterwards
    // rather than a second frame.
    task automatic drive_frame(input logic [7:0] data, input logic good_stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (good_stop) begin
            rx_drv = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (300) @(negedge clk);
            rx_drv = 1'b1;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.wr_en   = 1'b0;
        bus_if.din     = 8'h00;
        bus_if.rdy_clr = 1'b0;
        vecs[0] = '{data: 8'h41, inject: 1'b0, exp_dout: 8'h41};
        vecs[1] = '{data: 8'h55, inject: 1'b0, exp_dout: 8'h55};
        vecs[2] = '{data: 8'h00, inject: 1'b0, exp_dout: 8'h00};
        vecs[3] = '{data: 8'hFF, inject: 1'b0, exp_dout: 8'hFF};
        vecs[4] = '{data: 8'h41, inject: 1'b1, exp_dout: 8'h41};

        // Values while reset is held.
        #23;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_rdy", 32'(bus_if.rdy), 32'd0);
        check("reset_dout", 32'(bus_if.dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            tx_frame(vecs[v].data, vecs[v].inject, vecs[v].exp_dout);
            $display("vec %0d: din=0x%02h inject=%0d dout=0x%02h", v, vecs[v].data,
                     vecs[v].inject, bus_if.dout);
        end

        // A short low pulse on rx is a false start. A real frame right
        // after it must still be received.
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (50) @(negedge clk);
        rx_drv = 1'b0;
        repeat (4 * TICK_CLKS) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        check("false_start_rdy", 32'(bus_if.rdy), 32'd0);
        drive_frame(8'h5A, 1'b1);
        repeat (50) @(negedge clk);
        check("after_false_start_rdy", 32'(bus_if.rdy), 32'd1);
        check("after_false_start_dout", 32'(bus_if.dout), 32'h5A);
        $display("false start then 0x5A: rdy=%0d dout=0x%02h", bus_if.rdy, bus_if.dout);
        bus_if.rdy_clr = 1'b1;
        @(negedge clk);
        bus_if.rdy_clr = 1'b0;

        // A frame with a low stop bit is dropped.
        drive_frame(8'hC3, 1'b0);
        repeat (1500) @(negedge clk);
        check("framing_rdy", 32'(bus_if.rdy), 32'd0);
        check("framing_dout", 32'(bus_if.dout), 32'h5A);
        $display("framing error 0xC3: rdy=%0d dout=0x%02h", bus_if.rdy, bus_if.dout);

        // Reset in the middle of a transmit.
        loop_en = 1'b1;
        @(negedge clk);
        bus_if.din   = 8'h3C;
        bus_if.wr_en = 1'b1;
        @(posedge clk); #1;
        bus_if.wr_en = 1'b0;
        repeat (1500) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(bus_if.busy), 32'd0);
        check("midreset_dout", 32'(bus_if.dout), 32'd0);
        $display("mid-frame reset: tx=%0d busy=%0d", tx, bus_if.busy);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        tx_frame(8'h3C, 1'b0, 8'h3C);
        $display("post-reset 0x3C: dout=0x%02h", bus_if.dout);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_top.md
# uart_top

Full-duplex 8N1 UART with its own baud-tick generation. The transmitter serialises a byte written over a single-cycle `wr_en` strobe. The receiver deserialises the `rx` line using 16x oversampling and holds the byte with a sticky `rdy` flag until software clears it. It sits between a register/bus front end and the chip pins; `tx` may be looped to `rx` for self-test.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `TX_DIV` (localparam) = CLK_FREQ/BAUD = 434 clocks per transmitted bit.
- `RX_DIV` (localparam) = CLK_FREQ/(16*BAUD) = 27 clocks per receive oversample tick.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial input, idle high.
- `wr_en` in 1: one-cycle write strobe; `din` is accepted when high and `busy`=0.
- `din` in 8: byte to transmit.
- `rdy_clr` in 1: clears `rdy`.
- `tx` out 1: serial output, idle high.
- `busy` out 1: transmitter frame in progress.
- `rdy` out 1: received byte valid, sticky.
- `dout` out 8: last received byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: `tx`=1, `busy`=0, `rdy`=0, `dout`=0. Both FSMs go to IDLE and all counters clear.

Transmitter FSM (IDLE, START, DATA, STOP):
- In IDLE, `wr_en`=1 latches `din`, clears the bit counter and moves to START.
- `wr_en` while not IDLE is ignored; the frame in flight is unaffected.
- START drives 0 for TX_DIV clocks.
- DATA drives shift[0] for TX_DIV clocks per bit, for 8 bits.
- STOP drives 1 for TX_DIV clocks, then returns to IDLE.
- `busy` = (state != IDLE).

Receiver FSM (IDLE, START, DATA, STOP), advanced only on oversample ticks:
- IDLE: `rx`=0 on a tick moves to START with the sample count cleared.
- START: at sample 8 (mid-bit), `rx` still 0 moves to DATA. `rx`=1 is a false start; return to IDLE.
- DATA: sample every 16 ticks at mid-bit and shift in LSB first. After 8 bits move to STOP.
- STOP: at mid-bit, `rx`=1 loads `dout` and sets `rdy`. `rx`=0 is a framing error: the byte is discarded and `rdy` is unchanged. Either way, return to IDLE.
- `rdy` remains 1 until `rdy_clr`. A new byte arriving while `rdy`=1 overwrites `dout`.
- `rdy_clr` and a new byte set in the same cycle: the set wins.
- `rx` passes through a 2-flop synchroniser before use.

## Timing
- Accept-to-line: `tx` goes low and `busy` goes high on the clock edge that samples `wr_en`.
- `busy` stays high for exactly 10*TX_DIV = 4340 clocks.
- The next `wr_en` is accepted in the first cycle `busy`=0 (back-to-back frames are allowed).
- TX bit counter restarts on accept, so every bit is exactly TX_DIV clocks. The RX tick counter is free-running, modulo RX_DIV.
- Loopback latency: `rdy` rises about 9.5 bit times plus 2 sync clocks after the start edge, i.e. before `busy` falls. `rdy` stays high through `busy` falling.
- `rdy_clr` takes effect on the next edge; `rdy` is 0 in the following cycle.
- Reset mid-frame aborts both FSMs immediately: `tx`=1, `busy`=0. A partial received byte is discarded.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP), shared by TX and RX.
  - Constants: oversample factor 16, data bits 8.
- One sub-module, `uart_baud_gen`: parameterised divide-by-N counter producing a one-cycle tick, with synchronous restart input.
  - Instance 1 (TX_DIV): restarted on TX accept.
  - Instance 2 (RX_DIV): free-running.
- TX and RX FSMs live in `uart_top`.

## Test plan
- Loopback `tx`->`rx`: after reset, write 0x41.
  - `busy` rises, then falls after 4340 clocks.
  - `rdy`=1 and `dout`=0x41.
  - `rdy_clr` pulse drops `rdy` next cycle.
- Loopback 0x55, then 0x00 and 0xFF: each received exactly, and `tx` bit sequence verified LSB first with start=0 and stop=1.
- `wr_en` with 0xAA asserted mid-frame of 0x41 is ignored: only 0x41 is received, and `busy` length is unchanged.
- Drive `rx` low for 4 oversample ticks, then high: no `rdy`, RX returns to IDLE.
- Frame with stop bit forced to 0: `rdy` stays 0 and `dout` is unchanged.
- Assert `rst`=0 mid-transmit: `tx`=1 and `busy`=0 immediately (asynchronously). After release, a new write of 0x3C loops back correctly.
